// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: four-channel round-robin arbiter driving the 4:1 mux selects with a bounded hold time
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic       s1_o,
    output logic       s0_o,
    output logic [3:0] gnt_o,
    output logic       busy_o,
    output logic       expired_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d, owner_q, owner_d, sel_q, sel_d, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d, exp_q, exp_d, at_limit, own_req, rel;
    // descending scan so the requester closest to ptr (offset 0 first) wins
    always_comb begin
        pick = ptr_q;
        for (int i = 3; i >= 0; i--)
            if (req_i[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
    end
    assign at_limit = cnt_q == CNT_W'(MAX_HOLD - 1);
    assign own_req  = req_i[owner_q];
    assign rel      = done_i || !own_req || at_limit;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        sel_d   = sel_q;
        exp_d   = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                owner_d = pick;
                gnt_d   = 4'b0001 << pick;
                busy_d  = 1'b1;
                sel_d   = pick;
                cnt_d   = '0;
                state_d = GRANT;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (rel) begin
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                ptr_d   = owner_q + 2'd1;
                cnt_d   = '0;
                exp_d   = at_limit && !done_i && own_req;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            sel_q   <= 2'd0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            exp_q   <= exp_d;
        end
    end
    assign s1_o      = sel_q[1];
    assign s0_o      = sel_q[0];
    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign expired_o = exp_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: three hold limits (8, 4, 1) share stimulus; vector table, corner sequences and random traffic vs a cycle model
module tb_mux_sel_arbiter;
    typedef struct packed {
        logic act;
        logic exp;
        int   own;
        int   held;
        int   ptr;
        int   sel;
    } model_t;
    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [7:0] exp;
    } vec_t;
    logic       clk, rst, done;
    logic [3:0] req;
    logic [7:0] o8, o4, o1;
    int         pass_cnt = 0, tot_cnt = 0;
    int         hv[3] = '{8, 4, 1};
    model_t     m[3];
    vec_t       tbl[14];
    mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .s1_o(o8[7]), .s0_o(o8[6]), .gnt_o(o8[5:2]), .busy_o(o8[1]), .expired_o(o8[0]));
    mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .s1_o(o4[7]), .s0_o(o4[6]), .gnt_o(o4[5:2]), .busy_o(o4[1]), .expired_o(o4[0]));
    mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .s1_o(o1[7]), .s0_o(o1[6]), .gnt_o(o1[5:2]), .busy_o(o1[1]), .expired_o(o1[0]));
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic logic [7:0] outs(int i);
        return i == 0 ? o8 : i == 1 ? o4 : o1;
    endfunction
    function automatic logic [7:0] mout(model_t s);
        return {2'(s.sel), s.act ? 4'(1 << s.own) : 4'h0, s.act, s.exp};
    endfunction
    // held counts the grant cycles already seen; the owner leaves after h of them
    function automatic model_t step(model_t s, int h, logic [3:0] r, logic d);
        model_t n = s;
        int c = -1;
        n.exp = 0;
        if (!s.act) begin
            for (int k = 0; k < 4; k++)
                if (c < 0 && r[(s.ptr + k) % 4]) c = (s.ptr + k) % 4;
            if (c >= 0) begin
                n.act = 1; n.own = c; n.held = 1; n.sel = c;
            end
        end else if (d || !r[s.own] || s.held == h) begin
            n.exp = (s.held == h) && !d && r[s.own];
            n.act = 0;
            n.ptr = (s.own + 1) % 4;
        end else
            n.held = s.held + 1;
        return n;
    endfunction
    task automatic chk(string nm, int act, int expv);
        tot_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask
    task automatic cyc(logic [3:0] r, logic d);
        req = r;
        done = d;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step(m[i], hv[i], r, d);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("model_h%0d", hv[i]), outs(i), mout(m[i]));
    endtask
    task automatic do_reset();
        #2 rst = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            m[i] = '0;
            chk($sformatf("rst_async_h%0d", hv[i]), outs(i), 0);
        end
        #1 rst = 0;
    endtask
    initial begin
        int order[$], lens[$];
        int run, nexp;
        logic pb;
        logic [3:0] r;
        logic d;
        tbl[0]  = '{4'b0100, 1'b0, {2'b10, 4'b0100, 1'b1, 1'b0}};
        tbl[1]  = '{4'b0100, 1'b0, {2'b10, 4'b0100, 1'b1, 1'b0}};
        tbl[2]  = '{4'b0100, 1'b0, {2'b10, 4'b0100, 1'b1, 1'b0}};
        tbl[3]  = '{4'b0100, 1'b1, {2'b10, 4'b0000, 1'b0, 1'b0}};
        tbl[4]  = '{4'b0100, 1'b0, {2'b10, 4'b0100, 1'b1, 1'b0}};
        tbl[5]  = '{4'b0100, 1'b0, {2'b10, 4'b0100, 1'b1, 1'b0}};
        tbl[6]  = '{4'b0100, 1'b1, {2'b10, 4'b0000, 1'b0, 1'b0}};
        tbl[7]  = '{4'b0010, 1'b0, {2'b01, 4'b0010, 1'b1, 1'b0}};
        tbl[8]  = '{4'b1010, 1'b0, {2'b01, 4'b0010, 1'b1, 1'b0}};
        tbl[9]  = '{4'b1000, 1'b0, {2'b01, 4'b0000, 1'b0, 1'b0}};
        tbl[10] = '{4'b1000, 1'b0, {2'b11, 4'b1000, 1'b1, 1'b0}};
        tbl[11] = '{4'b0000, 1'b1, {2'b11, 4'b0000, 1'b0, 1'b0}};
        tbl[12] = '{4'b0000, 1'b0, {2'b11, 4'b0000, 1'b0, 1'b0}};
        tbl[13] = '{4'b0000, 1'b0, {2'b11, 4'b0000, 1'b0, 1'b0}};
        rst = 1; req = 0; done = 0;
        for (int i = 0; i < 3; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("reset_h%0d", hv[i]), outs(i), 0);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].req, tbl[i].done);
            chk($sformatf("vec%0d_h8", i), o8, tbl[i].exp);
            chk($sformatf("vec%0d_h4", i), o4, tbl[i].exp);
        end
        do_reset();
        cyc(4'b0100, 0);
        cyc(4'b0100, 0);
        chk("pre_rst_owner_ch2", o8, {2'b10, 4'b0100, 1'b1, 1'b0});
        do_reset();
        cyc(4'b1111, 0);
        chk("post_rst_grant_ch0", o8, {2'b00, 4'b0001, 1'b1, 1'b0});
        do_reset();
        run = 0; nexp = 0; pb = 0;
        for (int i = 0; i < 21; i++) begin
            cyc(4'b1111, 0);
            if (o4[1] && !pb) order.push_back(int'(o4[7:6]));
            if (o4[1]) run++;
            if (!o4[1] && pb) begin
                lens.push_back(run);
                run = 0;
            end
            if (o4[0]) nexp++;
            pb = o4[1];
        end
        chk("rr_grants", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++) chk($sformatf("rr_order%0d", i), order[i], i % 4);
        chk("rr_releases", lens.size(), 4);
        foreach (lens[i]) chk($sformatf("rr_len%0d", i), lens[i], 4);
        chk("rr_expired", nexp, 4);
        do_reset();
        repeat (4) cyc(4'b0001, 0);
        chk("limit_pre_busy", o4, {2'b00, 4'b0001, 1'b1, 1'b0});
        cyc(4'b0001, 1);
        chk("done_vs_limit", o4, {2'b00, 4'b0000, 1'b0, 1'b0});
        r = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 99) == 0) do_reset();
            cyc(r, d);
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
